// File: rtl/writeback_unit_if.sv
// Write-back bundle: ALU/load producer handshakes, register-file write
// port (DA/D/w), FIFO occupancy, optional bypass (WB_BYPASS_EN).
interface writeback_unit_if #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [4:0]            alu_da;
  logic [DATA_WIDTH-1:0] alu_d;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [4:0]            mem_da;
  logic [DATA_WIDTH-1:0] mem_d;
  logic [4:0]            DA;
  logic [DATA_WIDTH-1:0] D;
  logic                  w;
  logic [CW-1:0]         fifo_count;
`ifdef WB_BYPASS_EN
  logic [4:0]            AA;
  logic [4:0]            AB;
  logic                  fwd_a;
  logic                  fwd_b;

  modport master (
    output alu_valid, alu_da, alu_d,
    output mem_valid, mem_da, mem_d,
    output AA, AB,
    input  alu_ready, mem_ready,
    input  DA, D, w, fifo_count,
    input  fwd_a, fwd_b
  );

  modport slave (
    input  alu_valid, alu_da, alu_d,
    input  mem_valid, mem_da, mem_d,
    input  AA, AB,
    output alu_ready, mem_ready,
    output DA, D, w, fifo_count,
    output fwd_a, fwd_b
  );
`else
  modport master (
    output alu_valid, alu_da, alu_d,
    output mem_valid, mem_da, mem_d,
    input  alu_ready, mem_ready,
    input  DA, D, w, fifo_count
  );

  modport slave (
    input  alu_valid, alu_da, alu_d,
    input  mem_valid, mem_da, mem_d,
    output alu_ready, mem_ready,
    output DA, D, w, fifo_count
  );
`endif
endinterface

// File: rtl/writeback_unit.sv
// Write-back unit: loads issue with priority, ALU results via in-order
// FIFO; registered DA/D/w, X31 writes dropped. Macro: WB_BYPASS_EN.
module writeback_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input logic             clock,
  input logic             reset,
  writeback_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]            da;
    logic [DATA_WIDTH-1:0] d;
  } wb_ent_t;

  wb_ent_t               fifo [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  issue;
  wb_ent_t               sel;
  logic [4:0]            da_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic                  w_q;

  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;

  // Ready depends on current occupancy only: a full FIFO
  // refuses a push even while it pops.
  assign bus.alu_ready = !reset && !full;
  assign bus.mem_ready = !reset;

  assign push  = bus.alu_valid && bus.alu_ready;
  assign pop   = !bus.mem_valid && !empty;
  assign issue = bus.mem_valid || !empty;

  assign sel = bus.mem_valid
             ? {bus.mem_da, bus.mem_d}
             : fifo[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) fifo[wr_ptr] <= {bus.alu_da, bus.alu_d};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      da_q <= '0;
      d_q  <= '0;
      w_q  <= 1'b0;
    end else if (issue) begin
      da_q <= sel.da;
      d_q  <= sel.d;
      w_q  <= sel.da != 5'd31;
    end else begin
      w_q  <= 1'b0;
    end
  end

  assign bus.DA         = da_q;
  assign bus.D          = d_q;
  assign bus.w          = w_q;
  assign bus.fifo_count = count;

`ifdef WB_BYPASS_EN
  // The register file still shows the old value during the
  // write cycle, so the read stage must take D instead.
  assign bus.fwd_a = w_q && (da_q == bus.AA);
  assign bus.fwd_b = w_q && (da_q == bus.AB);
`endif
endmodule
